// File: rtl/hs32_elastic_pipe.sv
// hs32_elastic_pipe: chain of DEPTH skid-buffer stages with per-stage stall, flush and head taps
module hs32_elastic_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    localparam int CW = $clog2(2*DEPTH+1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [WIDTH-1:0]       data_i,
    input  logic [DEPTH-1:0]       stall_i,
    input  logic [DEPTH-1:0]       flush_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [DEPTH-1:0]       stg_vld_o,
    output logic [DEPTH*WIDTH-1:0] stg_data_o,
    output logic [CW-1:0]          count_o
);
    logic [DEPTH-1:0]       head_full, skid_full, rdy, out_vld, in_vld, dn_rdy, in_xfer, out_xfer;
    logic [DEPTH*WIDTH-1:0] head, skid, in_data;

    assign rdy      = ~skid_full;
    assign out_vld  = head_full & ~stall_i & ~flush_i;
    assign in_vld   = (out_vld << 1) | DEPTH'(valid_i);
    assign in_data  = (head << WIDTH) | (DEPTH*WIDTH)'(data_i);
    assign dn_rdy   = (rdy >> 1) | (DEPTH'(ready_i) << (DEPTH-1));
    assign in_xfer  = in_vld & rdy;
    assign out_xfer = out_vld & dn_rdy;

    assign ready_o    = rdy[0] & ~reset;
    assign valid_o    = out_vld[DEPTH-1];
    assign data_o     = head[(DEPTH-1)*WIDTH +: WIDTH];
    assign stg_vld_o  = head_full;
    assign stg_data_o = head;

    // occupancy is the number of set head and skid flags
    always_comb begin
        count_o = '0;
        for (int i = 0; i < DEPTH; i++)
            count_o = count_o + CW'(head_full[i]) + CW'(skid_full[i]);
    end

    // per-stage head/skid update; flush only clears flags, payloads stay stale
    always_ff @(posedge clk) begin
        if (reset) begin
            head_full <= '0;
            skid_full <= '0;
            head      <= '0;
            skid      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_i[i]) begin
                    head_full[i] <= 1'b0;
                    skid_full[i] <= 1'b0;
                end else if (out_xfer[i]) begin
                    if (skid_full[i]) begin
                        head[i*WIDTH +: WIDTH] <= skid[i*WIDTH +: WIDTH];
                        skid_full[i]           <= 1'b0;
                    end else begin
                        head_full[i] <= in_xfer[i];
                        if (in_xfer[i]) head[i*WIDTH +: WIDTH] <= in_data[i*WIDTH +: WIDTH];
                    end
                end else if (in_xfer[i]) begin
                    if (head_full[i]) begin
                        skid[i*WIDTH +: WIDTH] <= in_data[i*WIDTH +: WIDTH];
                        skid_full[i]           <= 1'b1;
                    end else begin
                        head[i*WIDTH +: WIDTH] <= in_data[i*WIDTH +: WIDTH];
                        head_full[i]           <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_hs32_elastic_pipe.sv
// tb_hs32_elastic_pipe: directed and random checks against a per-stage two-entry queue model
module tb_hs32_elastic_pipe;
    localparam int D = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset, valid_i, ready_o, ready_i, valid_o;
    logic [W-1:0]   data_i, data_o;
    logic [D-1:0]   stall_i, flush_i, stg_vld_o;
    logic [D*W-1:0] stg_data_o;
    logic [2:0]     count_o;

    hs32_elastic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .stg_vld_o(stg_vld_o), .stg_data_o(stg_data_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int           n_chk = 0, n_pass = 0, cyc = 0;
    int           mn[D];
    logic [W-1:0] me[D][2];
    logic         last_acc, last_emit;
    logic [W-1:0] outq[$];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic [D-1:0] st,
                        input logic [D-1:0] fl, input logic rr, input logic rs);
        logic         ov[D], rd[D], iv[D], dn[D], pop[D], push[D];
        logic [W-1:0] id[D];
        int           cnt;
        valid_i = v; data_i = d; stall_i = st; flush_i = fl; ready_i = rr; reset = rs;
        #1;
        cnt = 0;
        for (int k = 0; k < D; k++) begin
            ov[k] = mn[k] > 0 && !st[k] && !fl[k];
            rd[k] = mn[k] < 2;
            cnt += mn[k];
        end
        for (int k = 0; k < D; k++) begin
            if (k == 0) begin iv[k] = v; id[k] = d; end
            else begin iv[k] = ov[k-1]; id[k] = me[k-1][0]; end
            dn[k] = (k == D-1) ? rr : rd[(k+1) % D];
            pop[k]  = ov[k] && dn[k];
            push[k] = iv[k] && rd[k];
        end
        chk("ready_o", W'(ready_o), W'(rd[0] && !rs));
        chk("valid_o", W'(valid_o), W'(ov[D-1]));
        if (ov[D-1]) chk("data_o", data_o, me[D-1][0]);
        for (int k = 0; k < D; k++) begin
            chk("stg_vld_o", W'(stg_vld_o[k]), W'(mn[k] > 0));
            if (mn[k] > 0) chk("stg_data_o", stg_data_o[k*W +: W], me[k][0]);
        end
        chk("count_o", W'(count_o), W'(cnt));
        last_acc  = push[0] && !rs;
        last_emit = pop[D-1] && !rs;
        if (valid_o && ready_i && !rs) outq.push_back(data_o);
        @(posedge clk);
        for (int k = 0; k < D; k++) begin
            if (rs || fl[k]) mn[k] = 0;
            else begin
                if (pop[k]) begin me[k][0] = me[k][1]; mn[k]--; end
                if (push[k]) begin me[k][mn[k]] = id[k]; mn[k]++; end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        int first_acc, first_out, peak, nacc, nv;
        for (int k = 0; k < D; k++) mn[k] = 0;
        valid_i = 0; data_i = 0; stall_i = 0; flush_i = 0; ready_i = 0; reset = 1;
        @(posedge clk); #1;
        chk("reset_count", W'(count_o), 0);
        chk("reset_data_o", data_o, 0);
        chk("reset_stg_data", stg_data_o[W-1:0] | stg_data_o[2*W-1:W] | stg_data_o[3*W-1:2*W], 0);
        chk("reset_ready", W'(ready_o), 0);

        // 1: streaming with full throughput
        step(0, 0, 0, 0, 1, 0);
        nv = 1; first_acc = -1; first_out = -1; peak = 0; outq = {};
        for (int t = 0; t < 40 && outq.size() < 16; t++) begin
            step(nv <= 16, W'(nv), 0, 0, 1, 0);
            if (int'(count_o) > peak) peak = int'(count_o);
            if (last_acc) begin if (first_acc < 0) first_acc = t; nv++; end
            if (last_emit && first_out < 0) first_out = t;
        end
        chk("t1_latency", W'(first_out - first_acc), 3);
        chk("t1_peak", W'(peak), 3);
        chk("t1_outs", W'(outq.size()), 16);
        for (int i = 0; i < 16 && i < outq.size(); i++) chk("t1_order", outq[i], W'(i + 1));

        // 2: backpressure fills every skid, then drain
        nacc = 0; outq = {};
        for (int t = 0; t < 10; t++) begin
            step(1, W'(32'h100 + nacc), 0, 0, 0, 0);
            if (last_acc) nacc++;
        end
        chk("t2_accepts", W'(nacc), 6);
        chk("t2_ready", W'(ready_o), 0);
        chk("t2_count", W'(count_o), 6);
        for (int t = 0; t < 12; t++) step(0, 0, 0, 0, 1, 0);
        chk("t2_outs", W'(outq.size()), 6);
        for (int i = 0; i < 6 && i < outq.size(); i++) chk("t2_order", outq[i], W'(32'h100 + i));

        // 3: stall the middle stage
        nv = 32'h200; outq = {};
        for (int t = 0; t < 3; t++) begin step(1, W'(nv), 0, 0, 1, 0); if (last_acc) nv++; end
        for (int t = 0; t < 4; t++) begin step(1, W'(nv), 3'b010, 0, 1, 0); if (last_acc) nv++; end
        chk("t3_ready", W'(ready_o), 0);
        chk("t3_count", W'(count_o), 4);
        for (int t = 0; t < 12; t++) begin step(0, 0, 0, 0, 1, 0); end
        chk("t3_outs", W'(outq.size()), W'(nv - 32'h200));
        for (int i = 0; i < outq.size(); i++) chk("t3_order", outq[i], W'(32'h200 + i));

        // 4: flush stage 1 while 0xA sits there and 0xB enters
        outq = {};
        step(1, 32'h9, 0, 0, 1, 0);
        step(1, 32'hA, 0, 0, 1, 0);
        step(1, 32'hB, 0, 0, 1, 0);
        chk("t4_pre_count", W'(count_o), 3);
        step(1, 32'hC, 3'b010, 3'b010, 1, 0);
        chk("t4_post_count", W'(count_o), 1);
        step(1, 32'hD, 0, 0, 1, 0);
        step(1, 32'hE, 0, 0, 1, 0);
        for (int t = 0; t < 8; t++) step(0, 0, 0, 0, 1, 0);
        chk("t4_outs", W'(outq.size()), 4);
        if (outq.size() == 4) begin
            chk("t4_o0", outq[0], 32'h9);
            chk("t4_o1", outq[1], 32'hC);
            chk("t4_o2", outq[2], 32'hD);
            chk("t4_o3", outq[3], 32'hE);
        end

        // 5: reset with five entries in flight
        for (int t = 0; t < 5; t++) step(1, W'(32'h300 + t), 0, 0, 0, 0);
        chk("t5_pre_count", W'(count_o), 5);
        step(1, 32'h3FF, 0, 0, 1, 1);
        chk("t5_count", W'(count_o), 0);
        chk("t5_valid", W'(valid_o), 0);
        chk("t5_data", data_o, 0);
        outq = {}; first_out = -1;
        for (int t = 0; t < 10; t++) begin
            step(t < 4, W'(32'h400 + t), 0, 0, 1, 0);
            if (last_emit && first_out < 0) first_out = t;
        end
        chk("t5_latency", W'(first_out), 3);
        chk("t5_outs", W'(outq.size()), 4);

        // 6: random traffic, stalls, flushes and occasional reset
        for (int t = 0; t < 3000; t++) begin
            logic [D-1:0] fl;
            fl = ($urandom_range(0, 19) == 0) ? D'(1 << $urandom_range(0, D-1)) : '0;
            step($urandom_range(0, 3) != 0, $urandom, D'($urandom & $urandom), fl,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end
        for (int t = 0; t < 10; t++) step(0, 0, 0, 0, 1, 0);
        chk("t6_drained", W'(count_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
